// File: rtl/matrix_vec_mult_seq.sv
// Sequential fixed-point NOS x NOS matrix by vector multiplier: one signed MAC, row-major.
// Optional build macro MATRIX_VEC_MULT_ROUND_EN adds round-half-up before the FRAC shift.
module matrix_vec_mult_seq #(
  parameter int WIDTH      = 16,
  parameter int NOS        = 4,
  parameter int INT_DIGITS = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_en,
  input  logic             start_mult,
  input  logic [WIDTH-1:0] A [0:NOS-1][0:NOS-1],
  input  logic [WIDTH-1:0] B [0:NOS-1],
  output logic [WIDTH-1:0] res [0:NOS-1],
  output logic             end_mult,
  output logic             busy
);

  localparam int FRAC = WIDTH - INT_DIGITS;
  localparam int IW   = $clog2(NOS);
  localparam int ACCW = 2 * WIDTH + $clog2(NOS);
  localparam logic [IW-1:0] LAST = IW'(NOS - 1);
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [IW-1:0]            i_q, i_d, j_q, j_d;
  logic signed [ACCW-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]         res_q [0:NOS-1];
  logic [WIDTH-1:0]         res_d [0:NOS-1];
  logic                     end_mult_q, end_mult_d;
  logic                     busy_q, busy_d;

  logic signed [2*WIDTH-1:0] prod_s;
  logic signed [ACCW-1:0]    acc_final_s;
  logic signed [ACCW-1:0]    acc_rnd_s;
  logic signed [ACCW-1:0]    acc_shift_s;
  logic [WIDTH-1:0]          sat_s;

  function automatic logic [WIDTH-1:0] sat_f(input logic signed [ACCW-1:0] v);
    logic [WIDTH-1:0] r;
    if (v > SAT_MAX) begin
      r = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (v < SAT_MIN) begin
      r = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      r = v[WIDTH-1:0];
    end
    return r;
  endfunction

  assign prod_s      = $signed(A[i_q][j_q]) * $signed(B[j_q]);
  assign acc_final_s = acc_q + {{(ACCW-2*WIDTH){prod_s[2*WIDTH-1]}}, prod_s};

`ifdef MATRIX_VEC_MULT_ROUND_EN
  localparam logic signed [ACCW-1:0] RND_C = (FRAC > 0) ?
    ({{(ACCW-1){1'b0}}, 1'b1} << ((FRAC > 0) ? (FRAC - 1) : 0)) : {ACCW{1'b0}};
  assign acc_rnd_s = acc_final_s + RND_C;
`else
  assign acc_rnd_s = acc_final_s;
`endif

  // Arithmetic shift floors toward -inf; saturation then clamps to the element range.
  assign acc_shift_s = acc_rnd_s >>> FRAC;
  assign sat_s       = sat_f(acc_shift_s);

  // Next-state, counter, accumulator and result-row update.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    for (int k = 0; k < NOS; k++) begin
      res_d[k] = res_q[k];
    end
    case (state_q)
      IDLE: begin
        if (start_mult) begin
          state_d = MAC;
          i_d     = {IW{1'b0}};
          j_d     = {IW{1'b0}};
          acc_d   = {ACCW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        if (j_q == LAST) begin
          res_d[i_q] = sat_s;
          acc_d      = {ACCW{1'b0}};
          j_d        = {IW{1'b0}};
          if (i_q == LAST) begin
            state_d = DONE;
            i_d     = {IW{1'b0}};
          end else begin
            i_d = i_q + IW'(1);
          end
        end else begin
          acc_d = acc_final_s;
          j_d   = j_q + IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    end_mult_d = (state_d == DONE);
    busy_d     = (state_d != IDLE);
  end

  // State and datapath registers; everything holds while clk_en is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      i_q        <= {IW{1'b0}};
      j_q        <= {IW{1'b0}};
      acc_q      <= {ACCW{1'b0}};
      end_mult_q <= 1'b0;
      busy_q     <= 1'b0;
      for (int k = 0; k < NOS; k++) begin
        res_q[k] <= {WIDTH{1'b0}};
      end
    end else if (clk_en) begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      acc_q      <= acc_d;
      end_mult_q <= end_mult_d;
      busy_q     <= busy_d;
      for (int k = 0; k < NOS; k++) begin
        res_q[k] <= res_d[k];
      end
    end
  end

  assign res      = res_q;
  assign end_mult = end_mult_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_matrix_vec_mult_seq.sv
// Bench for matrix_vec_mult_seq: default Q16.0 and Q8.8 instances on shared stimulus,
// checked every cycle against a dot-product/handshake model.
module tb_matrix_vec_mult_seq;

  localparam int NOS = 4;
  localparam int NN  = NOS * NOS;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk_en;
  logic        start_mult;
  logic [15:0] A [0:NOS-1][0:NOS-1];
  logic [15:0] B [0:NOS-1];
  logic [15:0] res0 [0:NOS-1];
  logic [15:0] res1 [0:NOS-1];
  logic        end0, end1, busy0, busy1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  matrix_vec_mult_seq #(.WIDTH(16), .NOS(NOS), .INT_DIGITS(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start_mult(start_mult),
    .A(A), .B(B), .res(res0), .end_mult(end0), .busy(busy0));

  matrix_vec_mult_seq #(.WIDTH(16), .NOS(NOS), .INT_DIGITS(8)) dut1 (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start_mult(start_mult),
    .A(A), .B(B), .res(res1), .end_mult(end1), .busy(busy1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference row result: exact dot product, optional round, floor shift, clamp.
  function automatic logic [15:0] dot(input int frac, input int row);
    longint s;
    s = 0;
    for (int j = 0; j < NOS; j++) begin
      s += longint'($signed(A[row][j])) * longint'($signed(B[j]));
    end
`ifdef MATRIX_VEC_MULT_ROUND_EN
    if (frac > 0) s += longint'(1) << (frac - 1);
`endif
    s = s >>> frac;
    if (s > 64'sd32767) return 16'h7FFF;
    if (s < -64'sd32768) return 16'h8000;
    return 16'(s);
  endfunction

  // Model: k_m = enabled cycles since start (0 = idle); rows switch to the new result
  // once their last product has been accumulated.
  int          k_m;
  logic [15:0] old_m [0:1][0:NOS-1];
  logic [15:0] new_m [0:1][0:NOS-1];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_m <= 0;
      for (int d = 0; d < 2; d++)
        for (int r = 0; r < NOS; r++) begin
          old_m[d][r] <= 16'h0000;
          new_m[d][r] <= 16'h0000;
        end
    end else if (clk_en) begin
      if (k_m == 0) begin
        if (start_mult) begin
          k_m <= 1;
          for (int r = 0; r < NOS; r++) begin
            new_m[0][r] <= dot(0, r);
            new_m[1][r] <= dot(8, r);
          end
        end
      end else if (k_m == NN + 1) begin
        k_m <= 0;
        old_m <= new_m;
      end else begin
        k_m <= k_m + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy0", {31'd0, busy0}, {31'd0, k_m != 0});
    chk("busy1", {31'd0, busy1}, {31'd0, k_m != 0});
    chk("end0", {31'd0, end0}, {31'd0, k_m == NN + 1});
    chk("end1", {31'd0, end1}, {31'd0, k_m == NN + 1});
    for (int r = 0; r < NOS; r++) begin
      chk("res0_row", {16'd0, res0[r]},
          {16'd0, (k_m >= (r + 1) * NOS + 1) ? new_m[0][r] : old_m[0][r]});
      chk("res1_row", {16'd0, res1[r]},
          {16'd0, (k_m >= (r + 1) * NOS + 1) ? new_m[1][r] : old_m[1][r]});
    end
  end

  task automatic clear_ops();
    for (int r = 0; r < NOS; r++) begin
      B[r] = 16'h0000;
      for (int c = 0; c < NOS; c++) A[r][c] = 16'h0000;
    end
  endtask

  task automatic set_identity();
    clear_ops();
    for (int r = 0; r < NOS; r++) A[r][r] = 16'h0001;
  endtask

  // Called at negedge+1; returns enabled-cycle index where end_mult was seen, leaves at negedge+1.
  task automatic run_op(input bit toggle, input bit mid_start, output int en_at_end);
    int en_edges;
    bit seen;
    bit done;
    seen = 1'b0;
    done = 1'b0;
    en_at_end = -1;
    start_mult = 1'b1;
    clk_en = 1'b1;
    @(posedge clk);
    en_edges = 1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (end0 && !seen) begin
        seen = 1'b1;
        en_at_end = en_edges;
      end
      if (seen && !end0) begin
        done = 1'b1;
        break;
      end
      #1;
      start_mult = (mid_start && n == 7) ? 1'b1 : 1'b0;
      clk_en = toggle ? ~clk_en : 1'b1;
      @(posedge clk);
      if (clk_en) en_edges++;
    end
    #1;
    start_mult = 1'b0;
    clk_en = 1'b1;
    chk("op_completed", {31'd0, done}, 32'd1);
  endtask

  task automatic chk_res0(input logic [15:0] e0, e1, e2, e3);
    chk("lit_res0_0", {16'd0, res0[0]}, {16'd0, e0});
    chk("lit_res0_1", {16'd0, res0[1]}, {16'd0, e1});
    chk("lit_res0_2", {16'd0, res0[2]}, {16'd0, e2});
    chk("lit_res0_3", {16'd0, res0[3]}, {16'd0, e3});
  endtask

  initial begin
    int e;
    reset_n = 1'b0;
    clk_en = 1'b1;
    start_mult = 1'b0;
    clear_ops();
    @(negedge clk);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_end", {31'd0, end0}, 32'd0);
    chk("rst_res", {16'd0, res0[2]}, 32'd0);
    #1 reset_n = 1'b1;
    @(negedge clk); #1;

    // Identity, B=[1,2,3,4]
    set_identity();
    B[0] = 16'd1; B[1] = 16'd2; B[2] = 16'd3; B[3] = 16'd4;
    run_op(1'b0, 1'b0, e);
    chk("lat_identity", e, 32'd17);
    chk_res0(16'd1, 16'd2, 16'd3, 16'd4);

    // Mixed signs
    clear_ops();
    A[0][0] = 16'hFFFF; A[0][1] = 16'd2;
    for (int c = 0; c < NOS; c++) A[1][c] = 16'd3;
    B[0] = 16'd5; B[1] = 16'd1; B[2] = 16'hFFFE; B[3] = 16'd4;
    run_op(1'b0, 1'b0, e);
    chk_res0(16'hFFFD, 16'h0018, 16'h0000, 16'h0000);

    // Positive and negative saturation
    clear_ops();
    A[0][0] = 16'h7FFF; A[0][1] = 16'h7FFF;
    B[0] = 16'd2; B[1] = 16'd2;
    run_op(1'b0, 1'b0, e);
    chk("sat_pos", {16'd0, res0[0]}, 32'h7FFF);
    B[0] = 16'hFFFE; B[1] = 16'hFFFE;
    run_op(1'b0, 1'b0, e);
    chk("sat_neg", {16'd0, res0[0]}, 32'h8000);

    // Q8.8 on the second instance
    clear_ops();
    for (int r = 0; r < NOS; r++) begin
      A[r][r] = 16'h0180;
      B[r] = 16'h0100;
    end
    run_op(1'b0, 1'b0, e);
    for (int r = 0; r < NOS; r++) chk("q88_diag", {16'd0, res1[r]}, 32'h0180);
    A[0][0] = 16'h0001; B[0] = 16'h0080;
    run_op(1'b0, 1'b0, e);
`ifdef MATRIX_VEC_MULT_ROUND_EN
    chk("q88_half", {16'd0, res1[0]}, 32'h0001);
`else
    chk("q88_half", {16'd0, res1[0]}, 32'h0000);
`endif

    // clk_en toggling with a start pulse mid-MAC
    set_identity();
    B[0] = 16'd1; B[1] = 16'd2; B[2] = 16'd3; B[3] = 16'd4;
    run_op(1'b1, 1'b1, e);
    chk("lat_toggle", e, 32'd17);
    chk_res0(16'd1, 16'd2, 16'd3, 16'd4);
    repeat (25) @(negedge clk);
    #1;

    // Reset at MAC cycle 6 aborts the request
    B[0] = 16'd4; B[1] = 16'd3; B[2] = 16'd2; B[3] = 16'd1;
    start_mult = 1'b1;
    @(negedge clk); #1;
    start_mult = 1'b0;
    repeat (5) @(negedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy0}, 32'd0);
    chk("abort_res", {16'd0, res0[1]}, 32'd0);
    #1 reset_n = 1'b1;
    repeat (25) @(negedge clk);
    #1;
    run_op(1'b0, 1'b0, e);
    chk("lat_after_reset", e, 32'd17);
    chk_res0(16'd4, 16'd3, 16'd2, 16'd1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_vec_mult_seq.md
Name: matrix_vec_mult_seq

Overview:
- Sequential fixed-point NOS×NOS matrix by NOS×1 vector multiplier.
- It is the responder on the start_mult/end_mult handshake that the Kalman state-equation and covariance blocks drive.
- Uses one signed multiplier and one accumulator, iterating row-major. This trades latency for area so that several filter stages can each own a multiplier.

Parameters:
- WIDTH, 16, bit width of every signed two's-complement element.
- NOS, 4, matrix dimension (number of states); must be >= 2.
- INT_DIGITS, 16, integer bits per element including sign. FRAC = WIDTH - INT_DIGITS (0..WIDTH-1).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  clock enable; when low, all registers hold.
- start_mult  in  1  request; sampled only in IDLE with clk_en=1.
- A  in  [WIDTH-1:0] [0:NOS-1][0:NOS-1]  matrix operand.
- B  in  [WIDTH-1:0] [0:NOS-1]  vector operand.
- res  out  [WIDTH-1:0] [0:NOS-1]  result A×B, registered.
- end_mult  out  1  completion strobe.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; res all 0; row/column counters 0; accumulator 0.
  - end_mult=0, busy=0.
- Operands: A and B are read live. The caller holds them stable from the start_mult cycle until end_mult; the block does not latch them.
- FSM (advances only when clk_en=1):
  - IDLE: start_mult=1 -> MAC with i=0, j=0, acc=0. Otherwise stay in IDLE.
  - MAC: acc += A[i][j]*B[j], using the full signed 2·WIDTH product. The accumulator is 2·WIDTH+clog2(NOS) bits and never overflows.
  - MAC, when j=NOS-1: res[i] <= sat(acc_final >>> FRAC), acc <= 0, j <= 0, i <= i+1. acc_final includes the current product.
  - MAC, when i=NOS-1 and j=NOS-1: after the write above -> DONE.
  - DONE: end_mult=1 (decoded from state) -> IDLE.
- Scaling: arithmetic right shift by FRAC, truncating toward -inf (baseline).
- Saturation: results above 2^(WIDTH-1)-1 clamp to 0x7FFF. Results below -2^(WIDTH-1) clamp to 0x8000 (WIDTH=16 values).
- Latency: start sampled at enabled edge 0 -> NOS·NOS MAC cycles -> end_mult high during enabled cycle NOS·NOS+1 (17 for NOS=4). end_mult never coincides with the start cycle.
- end_mult is high for exactly one enabled cycle. If clk_en is low during DONE, end_mult stays high until the next enabled edge.
- res updates row by row during MAC. res is final and stable from end_mult until the next completion. It is not cleared by a new start.
- start_mult while busy (MAC or DONE) is ignored, with no queuing.
- Reset mid-operation aborts the operation: no end_mult is produced for the aborted request, and res returns to 0.

Optional Feature:
- Macro: MATRIX_VEC_MULT_ROUND_EN.
- Defined, and FRAC>0: before the shift, add 2^(FRAC-1) to acc_final (round half up), then saturate.
- Defined, and FRAC=0: identical to the undefined case.
- Undefined: truncation only, with no added logic.
- Latency is unchanged in both cases.

Test Plan:
- Defaults, clk_en=1, A=identity, B=[1,2,3,4], start one cycle -> end_mult pulses once at enabled cycle 17; res=[1,2,3,4]; busy high on cycles 1..17.
- Defaults, A row0=[-1,2,0,0], row1=[3,3,3,3], B=[5,1,-2,4] -> res[0]=-3 (0xFFFD), res[1]=24 (0x0018).
- Defaults, A row0=[0x7FFF,0x7FFF,0,0], B=[2,2,0,0] -> res[0]=0x7FFF. Negating B -> res[0]=0x8000.
- INT_DIGITS=8 (Q8.8), A=diag(0x0180), B=all 0x0100 -> res all 0x0180. Then A[0][0]=0x0001, B[0]=0x0080 -> res[0]=0x0000 without the macro, 0x0001 with MATRIX_VEC_MULT_ROUND_EN.
- clk_en toggling 1,0,1,0… with the identity test -> same res. end_mult on the 17th enabled cycle, held through the disabled cycle. A start_mult pulse mid-MAC -> no second end_mult.
- reset_n low for 1 cycle at MAC cycle 6 -> res=0, busy=0, no end_mult. A new start afterwards completes normally in 17 cycles.
